// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: four-phase march BIST driving a single-port RAM and reporting pass/fail, error count and first failing location
module ram_bist_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              write,
  output logic              select,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);
  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, CHK, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ferr_a_q, ferr_a_d;
  logic [DATA_W-1:0] exp_q, exp_d, ferr_d_q, ferr_d_d, pat;
  logic [ADDR_W+1:0] err_q, err_d;
  logic vld_q, vld_d, fail_q, fail_d, last, miss, bump;
  assign pat  = DATA_W'(addr_q);
  assign last = addr_q == ADDR_W'(DEPTH - 1);
  assign miss = vld_q && data_out != exp_q;
  assign bump = state_q inside {W0, R0, W1, R1};
  always_comb begin
    state_d  = state_q;
    addr_d   = bump ? (last ? '0 : addr_q + 1'b1) : addr_q;
    exp_d    = '0;
    vld_d    = 1'b0;
    err_d    = miss ? (&err_q ? err_q : err_q + 1'b1) : err_q;
    fail_d   = fail_q | miss;
    ferr_a_d = miss && !fail_q ? addr_q - 1'b1 : ferr_a_q;
    ferr_d_d = miss && !fail_q ? data_out : ferr_d_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = W0;
        addr_d   = '0;
        err_d    = '0;
        fail_d   = 1'b0;
        ferr_a_d = '0;
        ferr_d_d = '0;
      end
      W0: state_d = last ? R0 : W0;
      R0: begin
        state_d = last ? W1 : R0;
        exp_d   = pat;
        vld_d   = 1'b1;
      end
      W1: state_d = last ? R1 : W1;
      R1: begin
        state_d = last ? CHK : R1;
        exp_d   = ~pat;
        vld_d   = 1'b1;
      end
      CHK: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      exp_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= '0;
      fail_q   <= 1'b0;
      ferr_a_q <= '0;
      ferr_d_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      exp_q    <= exp_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      ferr_a_q <= ferr_a_d;
      ferr_d_q <= ferr_d_d;
    end
  end
  // The compare trails its read issue by one cycle, so the failing address is
  // one behind the counter; at the phase wrap the counter is 0 and this wraps to DEPTH-1.
  assign select         = bump;
  assign write          = state_q == W0 || state_q == W1;
  assign address        = addr_q;
  assign data_in        = state_q == W0 ? pat : state_q == W1 ? ~pat : '0;
  assign busy           = bump || state_q == CHK;
  assign done           = state_q == DONE;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_a_q;
  assign first_err_data = ferr_d_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed self-checking bench for ram_bist_ctrl with behavioural RAM models
module tb_ram_bist_ctrl;
  logic clk = 0, reset = 0, start = 0, s_start = 0;
  logic [9:0] address, data_in, data_out, fea, fed;
  logic write, select, busy, done, fail;
  logic [11:0] err_count;
  logic [3:0] s_addr, s_fea;
  logic [7:0] s_din, s_dout, s_fed;
  logic s_wr, s_sel, s_busy, s_done, s_fail;
  logic [5:0] s_err;
  logic [9:0] mem [1024];
  logic [7:0] s_mem [16];
  logic [7:0] s_w15 [2];
  int mode = 0, wcnt = 0, wbad = 0, s_wcnt = 0, checks = 0, failures = 0, cyc;
  always #5 clk = ~clk;
  ram_bist_ctrl dut (.clk(clk), .reset(reset), .start(start), .address(address), .data_in(data_in),
    .write(write), .select(select), .data_out(data_out), .busy(busy), .done(done), .fail(fail),
    .err_count(err_count), .first_err_addr(fea), .first_err_data(fed));
  ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_s (.clk(clk), .reset(reset), .start(s_start),
    .address(s_addr), .data_in(s_din), .write(s_wr), .select(s_sel), .data_out(s_dout), .busy(s_busy),
    .done(s_done), .fail(s_fail), .err_count(s_err), .first_err_addr(s_fea), .first_err_data(s_fed));
  always @(posedge clk) if (select) begin
    if (write) begin
      mem[address] <= (mode == 2 && address == 10'd700 && data_in == 10'd700) ? 10'h3FF : data_in;
      if (wcnt < 1024 ? (address != wcnt[9:0] || data_in != wcnt[9:0])
                      : (address != 10'(wcnt - 1024) || data_in != ~10'(wcnt - 1024))) wbad++;
      wcnt++;
    end else data_out <= mem[address] | (mode == 1 ? 10'h008 : 10'h000);
  end
  always @(posedge clk) if (s_sel) begin
    if (s_wr) begin
      s_mem[s_addr] <= s_din;
      if (s_addr == 4'd15 && s_wcnt < 2) begin s_w15[s_wcnt] <= s_din; s_wcnt++; end
    end else s_dout <= s_mem[s_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int poke, output int n);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (busy && n < 20000) begin
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", select, 0);
    check("rst_addr", address, 0);
    check("rst_err", err_count, 0);
    check("rst_fail", fail, 0);
    reset = 1;
    run(-1, cyc);
    check("clean_cycles", cyc, 4097);
    check("clean_done", done, 1);
    check("clean_sel", select, 0);
    check("clean_fail", fail, 0);
    check("clean_err", err_count, 0);
    check("wlog_count", wcnt, 2048);
    check("wlog_bad", wbad, 0);
    mode = 1;
    run(-1, cyc);
    check("stuck_cycles", cyc, 4097);
    check("stuck_fail", fail, 1);
    check("stuck_err", err_count, 1024);
    check("stuck_faddr", fea, 0);
    check("stuck_fdata", fed, 10'h008);
    mode = 2;
    run(-1, cyc);
    check("word_done", done, 1);
    check("word_fail", fail, 1);
    check("word_err", err_count, 1);
    check("word_faddr", fea, 700);
    check("word_fdata", fed, 10'h3FF);
    mode = 0;
    run(2 * 1024 + 10, cyc);
    check("midw1_cycles", cyc, 4097);
    check("midw1_fail", fail, 0);
    check("midw1_err", err_count, 0);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (1224) @(negedge clk);
    check("r0_addr", address, 200);
    check("r0_write", write, 0);
    reset = 0;
    @(negedge clk);
    check("abort_sel", select, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", address, 0);
    reset = 1;
    run(-1, cyc);
    check("rerun_cycles", cyc, 4097);
    check("rerun_fail", fail, 0);
    @(negedge clk) s_start = 1;
    @(negedge clk) s_start = 0;
    cyc = 0;
    while (s_busy && cyc < 1000) begin @(negedge clk); cyc++; end
    check("small_cycles", cyc, 65);
    check("small_done", s_done, 1);
    check("small_fail", s_fail, 0);
    check("small_w15", s_w15[0], 8'h0F);
    check("small_w15inv", s_w15[1], 8'hF0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the single-port `ram` block; it drives the RAM's address, data_in, write and select pins and checks data_out.
- Runs a four-phase march over every address: write pattern, read/check, write inverted pattern, read/check inverted.
- Reports pass/fail, error count and first failing location to the system controller.
- Sits between the RAM instance and the top-level control/status logic.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 10, RAM data width.
- DEPTH, 1024, number of words tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a test.
- address  output  ADDR_W  RAM address.
- data_in  output  DATA_W  RAM write data.
- write  output  1  RAM write enable, qualified by select.
- select  output  1  RAM chip select.
- data_out  input  DATA_W  RAM read data, valid one cycle after a read issue.
- busy  output  1  test in progress.
- done  output  1  test finished; held until the next start or reset.
- fail  output  1  sticky; at least one miscompare.
- err_count  output  ADDR_W+2  number of miscompares, saturating at all-ones.
- first_err_addr  output  ADDR_W  address of the first miscompare.
- first_err_data  output  DATA_W  data_out value read at the first miscompare.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; address, data_in, write, select, busy, done, fail, err_count, first_err_* all 0. Reset mid-test aborts at that edge: select=0, no further RAM access.
- States: IDLE, W0, R0, W1, R1, CHK, DONE.
- IDLE or DONE with start=1: clear fail, err_count, first_err_* and done; go to W0 with addr=0; busy=1 from the next cycle. start is ignored in W0..CHK.
- Pattern: P(a) = a zero-extended or truncated to DATA_W. The W1/R1 phases use ~P(a).
- W0/W1: one write per cycle with select=1, write=1, address=a, data_in=pattern(a). After a=DEPTH-1, next state is R0 or R1 with a=0.
- R0/R1: one read issue per cycle with select=1, write=0, address=a, data_in=0. The expected value and a valid flag are registered alongside each issue.
- Compare is pipelined: the cycle after each issue, data_out is compared with the registered expected value.
  - This compare overlaps the next issue, including the first W1 write after R0.
  - After the R1 issue at DEPTH-1, go to CHK: select=0, final compare.
- Miscompare:
  - err_count increments, saturating.
  - fail=1.
  - If this is the first error, capture first_err_addr and first_err_data.
- CHK -> DONE: busy=0, done=1, select=0, write=0.
- Latency: busy is high for exactly 4*DEPTH+1 cycles. done rises on the following cycle.
- select=0 whenever state is IDLE, CHK or DONE. write=1 only in W0/W1.
- Address wrap: the address counter stops at DEPTH-1 and resets to 0 on each phase change; it never exceeds DEPTH-1.

Test Plan:
- Fault-free behavioural RAM, DEPTH=1024, one start pulse:
  - busy high for 4097 cycles, then done=1, fail=0, err_count=0.
  - Bench write log shows 0..1023 with data=a, then ~a.
- RAM model with data_out bit 3 stuck at 1:
  - fail=1, first_err_addr=0, first_err_data=10'h008.
  - err_count=1024: R0 fails where a[3]=0 (512), R1 fails where ~a[3]=0 (512).
- Single corrupted word (address 700 reads 10'h3FF in R0 only): err_count=1, first_err_addr=700, first_err_data=10'h3FF.
- reset=0 asserted during R0 at address 200: on the next edge select=0, busy=0, all status cleared; a later start reruns the full 4097-cycle test.
- start pulsed again mid-W1: ignored, timing unchanged. start pulsed in DONE: done clears, a new test runs, and stale err_count/fail are cleared.
- DEPTH=16, ADDR_W=4, DATA_W=8: pattern zero-extended (address 15 -> 8'h0F, inverted 8'hF0); busy high for 65 cycles.
